// File: rtl/pipe_pkg.sv
// pipe_pkg: mode encodings and occupancy width helper shared by the pipe_chain slice
package pipe_pkg;
  localparam int PIPE_MODE_FWD = 0;
  localparam int PIPE_MODE_FULL = 1;
  // Bits needed to count up to the peak number of held beats; never below 1.
  function automatic int occ_width(input int depth, input int mode);
    int cap = (mode == PIPE_MODE_FULL) ? 2 * depth : depth;
    int w = 1;
    while ((1 << w) <= cap) w++;
    return w;
  endfunction
endpackage

// File: rtl/pipe_slice.sv
// pipe_slice: one valid/ready register slice, forward-registered or full-registered (skid)
module pipe_slice
  import pipe_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int MODE = PIPE_MODE_FWD
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              valid_up,
  input  logic [DATA_W-1:0] data_up,
  output logic              ready_up,
  output logic              valid_dn,
  output logic [DATA_W-1:0] data_dn,
  input  logic              ready_dn,
  output logic [1:0]        cnt
);
  if (MODE == PIPE_MODE_FULL) begin : g_skid
    logic mv, sv, main_free;
    logic [DATA_W-1:0] md, sd;
    assign main_free = ~mv | ready_dn;
    assign ready_up = ~sv;
    assign valid_dn = mv;
    assign data_dn = md;
    assign cnt = {1'b0, mv} + {1'b0, sv};
    // Valid bits: a freed main is refilled from skid first; a stalled main spills into skid.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        mv <= 1'b0;
        sv <= 1'b0;
      end else if (flush) begin
        mv <= 1'b0;
        sv <= 1'b0;
      end else if (main_free) begin
        mv <= sv | valid_up;
        sv <= 1'b0;
      end else begin
        sv <= sv | valid_up;
      end
    // Payloads follow the valid moves; a flush leaves them untouched.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        md <= '0;
        sd <= '0;
      end else if (!flush) begin
        if (main_free & (sv | valid_up)) md <= sv ? sd : data_up;
        if (~main_free & ~sv & valid_up) sd <= data_up;
      end
  end else begin : g_fwd
    logic v;
    logic [DATA_W-1:0] d;
    assign ready_up = ready_dn | ~v;
    assign valid_dn = v;
    assign data_dn = d;
    assign cnt = {1'b0, v};
    // Single register: load whenever the slot is empty or being emptied downstream.
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v <= 1'b0;
        d <= '0;
      end else if (flush) begin
        v <= 1'b0;
      end else if (ready_up) begin
        v <= valid_up;
        if (valid_up) d <= data_up;
      end
  end
endmodule

// File: rtl/pipe_chain.sv
// pipe_chain: DEPTH chained valid/ready slices with synchronous flush and occupancy count
module pipe_chain
  import pipe_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int DEPTH = 1,
  parameter int MODE = PIPE_MODE_FWD,
  parameter int OCC_W = occ_width(DEPTH, PIPE_MODE_FULL)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic [OCC_W-1:0]  occ,
  output logic              busy
);
  if (MODE != PIPE_MODE_FWD && MODE != PIPE_MODE_FULL) begin : g_bad_mode
    $error("pipe_chain: MODE must be 0 or 1");
  end
  if (DEPTH < 0 || DEPTH > 8) begin : g_bad_depth
    $error("pipe_chain: DEPTH must be within 0..8");
  end
  if (DEPTH == 0) begin : g_pass
    assign out_valid = in_valid;
    assign out_data = in_data;
    assign in_ready = out_ready & ~flush;
    assign occ = '0;
  end else begin : g_pipe
    for (genvar i = 0; i < DEPTH; i++) begin : g_s
      logic vu, ru, vd, rd;
      logic [DATA_W-1:0] du, dd;
      logic [1:0] n;
      logic [OCC_W-1:0] acc;
      if (i == 0) begin : g_head
        assign vu = in_valid;
        assign du = in_data;
        assign acc = OCC_W'(n);
      end else begin : g_link
        assign vu = g_s[i-1].vd;
        assign du = g_s[i-1].dd;
        assign acc = g_s[i-1].acc + OCC_W'(n);
      end
      if (i == DEPTH - 1) begin : g_tail
        assign rd = out_ready;
      end else begin : g_next
        assign rd = g_s[i+1].ru;
      end
      pipe_slice #(.DATA_W(DATA_W), .MODE(MODE)) u_slice (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .valid_up(vu),
        .data_up(du),
        .ready_up(ru),
        .valid_dn(vd),
        .data_dn(dd),
        .ready_dn(rd),
        .cnt(n)
      );
    end
    assign in_ready = g_s[0].ru & ~flush;
    assign out_valid = g_s[DEPTH-1].vd;
    assign out_data = g_s[DEPTH-1].dd;
    assign occ = g_s[DEPTH-1].acc;
  end
  assign busy = |occ;
endmodule

// File: tb/tb_pipe_chain.sv
// tb_pipe_chain: directed vector table, hand sequences and a random scoreboard over several configurations
module tb_pipe_chain;
  import pipe_pkg::*;
  localparam int N = 8;
  localparam logic [31:0] DEPS = {4'd4, 4'd4, 4'd1, 4'd1, 4'd0, 4'd2, 4'd2, 4'd3};
  localparam logic [7:0] MODES = 8'b1010_0011;
  logic clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic [N-1:0] ir, ov, bz;
  logic [7:0] od [N];
  logic [3:0] oc [N];
  int vecs = 0, errs = 0;
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int D = int'(DEPS[g*4 +: 4]);
    localparam int M = int'(MODES[g]);
    localparam int W = occ_width(D, PIPE_MODE_FULL);
    logic [W-1:0] o;
    pipe_chain #(.DATA_W(8), .DEPTH(D), .MODE(M)) u_dut (
      .clk(clk),
      .rst_n(rst_n),
      .flush(flush),
      .in_valid(in_valid),
      .in_data(in_data),
      .in_ready(ir[g]),
      .out_valid(ov[g]),
      .out_data(od[g]),
      .out_ready(out_ready),
      .occ(o),
      .busy(bz[g])
    );
    assign oc[g] = 4'(o);
  end
  typedef struct {
    int u;
    logic rs, iv;
    logic [7:0] id;
    logic ordy, fl, er, eov;
    logic [7:0] eod;
    int eocc;
  } vec_t;
  vec_t tbl [64];
  int nv = 0;
  logic [7:0] mem [N][16];
  int cnt [N], hd [N];
  task automatic chk(input string name, input int act, input int exp);
    vecs++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask
  task automatic add(input int u, input logic rs, input logic iv, input logic [7:0] id,
                     input logic ordy, input logic fl, input logic er, input logic eov,
                     input logic [7:0] eod, input int eocc);
    tbl[nv] = '{u, rs, iv, id, ordy, fl, er, eov, eod, eocc};
    nv++;
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_data = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    int e_occ;
    // DEPTH=2 skid: capacity 4, release in order, then flush with occ=3, then a fresh beat
    add(1, 1, 1, 8'h01, 0, 0, 1, 0, 8'h00, 0);
    add(1, 0, 1, 8'h02, 0, 0, 1, 0, 8'h00, 1);
    add(1, 0, 1, 8'h03, 0, 0, 1, 1, 8'h01, 2);
    add(1, 0, 1, 8'h04, 0, 0, 1, 1, 8'h01, 3);
    add(1, 0, 1, 8'h05, 0, 0, 0, 1, 8'h01, 4);
    add(1, 0, 1, 8'h06, 0, 0, 0, 1, 8'h01, 4);
    add(1, 0, 0, 8'h00, 1, 0, 0, 1, 8'h01, 4);
    add(1, 0, 0, 8'h00, 1, 0, 0, 1, 8'h02, 3);
    add(1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h03, 2);
    add(1, 0, 0, 8'h00, 1, 0, 1, 1, 8'h04, 1);
    add(1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    add(1, 0, 1, 8'h11, 0, 0, 1, 0, 8'h00, 0);
    add(1, 0, 1, 8'h12, 0, 0, 1, 0, 8'h00, 1);
    add(1, 0, 1, 8'h13, 0, 0, 1, 1, 8'h11, 2);
    add(1, 0, 1, 8'hAA, 0, 1, 0, 1, 8'h11, 3);
    add(1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    add(1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    add(1, 0, 1, 8'hBB, 1, 0, 1, 0, 8'h00, 0);
    add(1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 1);
    add(1, 0, 0, 8'h00, 1, 0, 1, 1, 8'hBB, 1);
    add(1, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    // DEPTH=2 forward: combinational stall once both slices hold beats, no loss on release
    add(2, 1, 1, 8'h31, 0, 0, 1, 0, 8'h00, 0);
    add(2, 0, 1, 8'h32, 0, 0, 1, 0, 8'h00, 1);
    add(2, 0, 1, 8'h33, 0, 0, 0, 1, 8'h31, 2);
    add(2, 0, 1, 8'h33, 1, 0, 1, 1, 8'h31, 2);
    add(2, 0, 0, 8'h00, 1, 0, 1, 1, 8'h32, 2);
    add(2, 0, 0, 8'h00, 1, 0, 1, 1, 8'h33, 1);
    add(2, 0, 0, 8'h00, 1, 0, 1, 0, 8'h00, 0);
    // DEPTH=0 passthrough: flush masks in_ready only
    add(3, 1, 1, 8'h5A, 1, 1, 0, 1, 8'h5A, 0);
    add(3, 0, 1, 8'h5B, 1, 0, 1, 1, 8'h5B, 0);
    add(3, 0, 1, 8'h5C, 0, 0, 0, 1, 8'h5C, 0);
    #1;
    chk("reset out_valid", ov[1], 0);
    chk("reset out_data", od[1], 0);
    chk("reset in_ready", ir[1], 1);
    chk("reset occ", oc[1], 0);
    chk("reset busy", bz[1], 0);
    chk("reset out_valid d4", ov[6], 0);
    for (int k = 0; k < nv; k++) begin
      if (tbl[k].rs) do_reset();
      @(negedge clk);
      in_valid = tbl[k].iv;
      in_data = tbl[k].id;
      out_ready = tbl[k].ordy;
      flush = tbl[k].fl;
      #1;
      chk($sformatf("v%0d in_ready", k), ir[tbl[k].u], tbl[k].er);
      chk($sformatf("v%0d out_valid", k), ov[tbl[k].u], tbl[k].eov);
      chk($sformatf("v%0d occ", k), oc[tbl[k].u], tbl[k].eocc);
      chk($sformatf("v%0d busy", k), bz[tbl[k].u], tbl[k].eocc != 0);
      if (tbl[k].eov) chk($sformatf("v%0d out_data", k), od[tbl[k].u], tbl[k].eod);
    end
    // DEPTH=3 skid streaming 0x01..0x10 with out_ready held high
    do_reset();
    for (int c = 0; c < 21; c++) begin
      @(negedge clk);
      in_valid = c < 16;
      in_data = 8'(c + 1);
      out_ready = 1'b1;
      #1;
      e_occ = (c < 16 ? c : 16) - (c < 3 ? 0 : (c > 19 ? 16 : c - 3));
      chk($sformatf("stream c%0d in_ready", c), ir[0], 1);
      chk($sformatf("stream c%0d occ", c), oc[0], e_occ);
      chk($sformatf("stream c%0d out_valid", c), ov[0], c >= 3 && c < 19);
      if (c >= 3 && c < 19) chk($sformatf("stream c%0d out_data", c), od[0], c - 2);
    end
    // asynchronous reset while DEPTH=2 skid holds two beats
    do_reset();
    @(negedge clk);
    in_valid = 1'b1;
    in_data = 8'h71;
    @(negedge clk);
    in_data = 8'h72;
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("pre-reset occ", oc[1], 2);
    chk("pre-reset out_valid", ov[1], 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async reset out_valid", ov[1], 0);
    chk("async reset out_data", od[1], 0);
    chk("async reset in_ready", ir[1], 1);
    chk("async reset occ", oc[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    // random traffic on every configuration against a per-instance FIFO model
    do_reset();
    for (int g = 0; g < N; g++) begin
      cnt[g] = 0;
      hd[g] = 0;
    end
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      in_valid = $urandom_range(3) != 0;
      in_data = 8'(c);
      out_ready = c < 200 ? $urandom_range(1) != 0 : c < 400 ? $urandom_range(3) == 0 : $urandom_range(9) != 0;
      if (c >= 560) begin
        in_valid = 1'b0;
        out_ready = 1'b1;
      end
      #1;
      for (int g = 0; g < N; g++) begin
        chk($sformatf("rand c%0d u%0d occ", c, g), oc[g], cnt[g]);
        if (in_valid && ir[g]) begin
          mem[g][(hd[g] + cnt[g]) % 16] = in_data;
          cnt[g]++;
        end
        if (cnt[g] == 0) chk($sformatf("rand c%0d u%0d empty emit", c, g), int'(ov[g] & out_ready), 0);
        else if (ov[g] && out_ready) begin
          chk($sformatf("rand c%0d u%0d out_data", c, g), od[g], mem[g][hd[g]]);
          hd[g] = (hd[g] + 1) % 16;
          cnt[g]--;
        end
      end
    end
    for (int g = 0; g < N; g++) chk($sformatf("drained u%0d", g), cnt[g], 0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pipe_chain.md
# pipe_chain

Parametrised valid/ready pipeline of DEPTH register slices used on NPU datapaths: core↔NoC, buffer↔PE. Each slice runs in one of two modes:
- forward-registered: registered valid/data, combinational ready.
- full-registered (skid): registered valid/data and registered ready.

The block adds a synchronous flush and an occupancy count. It replaces hand-chained single forward stages.

## Interface
- DATA_W, 256, payload width (≥1)
- DEPTH, 1, number of slices (0 = combinational passthrough, up to 8)
- MODE, 0, 0 = forward-registered, 1 = full-registered (skid)
- OCC_W, $clog2(2*DEPTH+1), occupancy width (derived, not overridden)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- flush  in  1  synchronous flush; discards all held beats
- in_valid  in  1  upstream beat valid
- in_data  in  DATA_W  upstream payload
- in_ready  out  1  block accepts beat this cycle
- out_valid  out  1  downstream beat valid
- out_data  out  DATA_W  downstream payload
- out_ready  in  1  downstream accepts beat
- occ  out  OCC_W  beats currently held (sum of all slice valid bits)
- busy  out  1  occ != 0

## Operation
- Transfer occurs on any interface when valid & ready are both high at the rising clk edge.
- Beats leave in acceptance order. No duplication or loss except on flush.
- Slice k input connects to slice k-1 output. Slice 0 takes in_*; slice DEPTH-1 drives out_*.

MODE 0 slice:
- One register: v, d.
- ready_up = ready_dn | ~v.
- On ready_up: v <= valid_up; d <= data_up when valid_up.

MODE 1 slice:
- Main register mv/md, skid register sv/sd.
- ready_up = ~sv. It is a register output, so no combinational path from ready_dn.
- Main empty, or main draining this cycle: an accepted beat goes to main.
- Main full and stalled: an accepted beat goes to skid.
- When main drains and sv=1: skid moves to main and sv clears.
- Output comes from main only.

Flush:
- Clears every v/mv/sv on the next edge. Data registers keep their values.
- in_ready is forced to 0 while flush=1, so no beat is accepted during a flush cycle.
- out_valid still reflects pre-flush state in that cycle. Downstream must treat a beat taken in a flush cycle as consumed; the flush does not retract it.

DEPTH=0:
- out_* = in_*; in_ready = out_ready & ~flush; occ=0.
- MODE is ignored.

## Timing
- Reset values: out_valid 0, out_data 0, in_ready 1, occ 0, busy 0. All valid bits 0; all data registers 0.
- Latency: an accepted beat appears on out_valid exactly DEPTH cycles later if never stalled.
- Throughput: 1 beat/cycle in both modes with out_ready held 1.
- Stall, MODE 0: out_ready low propagates to in_ready in the same cycle once all slices are full. Capacity is DEPTH beats.
- Stall, MODE 1: in_ready falls one cycle after the first skid fills. Capacity is 2*DEPTH beats. in_ready rises one cycle after out_ready returns and the skid drains.
- Simultaneous accept and emit keeps occ unchanged.
- Max occ: DEPTH for MODE 0, 2*DEPTH for MODE 1. OCC_W covers both.
- flush together with in_valid: the beat is dropped (in_ready=0). flush together with out_ready: the output beat is transferred, then cleared.
- Async reset mid-transfer clears all state immediately. Outputs take their reset values while rst_n=0.

## Structure
- Package pipe_pkg:
  - localparams PIPE_MODE_FWD=0 and PIPE_MODE_FULL=1.
  - function occ_width(depth, mode).
- One sub-module, pipe_slice (DATA_W, MODE), instantiated DEPTH times in a generate loop. Each instance exports its held-beat count (0–2) for the occ adder.
- Elaboration-time assertions: MODE ∈ {0,1}; DEPTH ≤ 8.

## Test plan
All scenarios use DATA_W=8 unless noted.
- Streaming: DEPTH=3, MODE=1, out_ready=1; drive 0x01..0x10 back-to-back → out_data 0x01..0x10 on consecutive cycles, first at cycle 3 after accept; occ steady at 3.
- Backpressure capacity: DEPTH=2, MODE=1; hold out_ready=0 and drive continuously → exactly 4 beats accepted; in_ready=0 from the cycle after the 4th accept; occ=4. Release → 4 beats in order, one per cycle.
- MODE 0 stall: DEPTH=2, out_ready=0 after 2 beats → in_ready=0 in the same cycle both slices are full; occ=2; no loss on release.
- Flush: DEPTH=2, MODE=1, occ=3; pulse flush one cycle with in_valid=1, in_data=0xAA → in_ready=0 that cycle; occ=0 and out_valid=0 next cycle; 0xAA never emitted.
- Reset mid-stream: assert rst_n=0 asynchronously with occ=2 → out_valid=0, out_data=0, in_ready=1, occ=0 before the next clk edge.
- Random: DEPTH∈{0,1,4}, MODE∈{0,1}, random in_valid/out_ready; the scoreboard shows in-order, lossless delivery, and occ always equals the scoreboard count.
